wino_btdb_22_21_stream: RTL and testbench

// - Streaming Winograd input (data) transform V = BT*d*B for the 22_21 tile shape. It is the front-end

---
 rtl/wino_btdb_22_21_stream.sv | 164 ++++++++++++++++
 tb/tb_wino_btdb_22_21_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wino_btdb_22_21_stream.sv
// -----------------------------------------------------------------------------
// wino_btdb_22_21_stream
//
// Streaming Winograd input transform V = BT * d * B for the 22_21 tile shape.
//   BT = [[1,1,0],[1,-1,0],[-1,0,1]], B = identity in the 2-wide dimension.
// A 3x2 data tile arrives serially (row-major d[0..5]). It is buffered and
// transformed in one cycle, then emitted serially as the 3x2 tile v[0..5].
// There is no overlap between tiles: LOAD -> CALC -> SEND -> LOAD.
//
// Handshake (both ports): a beat transfers on a cycle where valid && ready
// are both high. While m_valid is high and m_ready is low, m_data and m_last
// are held and m_valid stays high until the beat is accepted.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_valid    in   input element valid
//   s_ready    out  input element accepted this cycle (high only in LOAD)
//   s_data     in   input element d[k], two's complement
//   s_last     in   upstream end-of-tile marker, checked only
//   m_valid    out  output element valid (high only in SEND)
//   m_ready    in   downstream accepts output element
//   m_data     out  output element v[k], two's complement
//   m_last     out  high with v[5]
//   frame_err  out  one-cycle pulse after a beat whose s_last disagrees
//                   with the element count
//   dbg_state  out  current FSM state (0 LOAD, 1 CALC, 2 SEND)
// -----------------------------------------------------------------------------
module wino_btdb_22_21_stream #(
    parameter int data_width = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [data_width-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic                  m_last,
    output logic                  frame_err,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]            in_cnt;
    logic [2:0]            out_cnt;
    logic [data_width-1:0] d_buf [6];
    logic [data_width-1:0] v_buf [6];
    logic                  s_fire;
    logic                  m_fire;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && (in_cnt == 3'd5)) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = SEND;
            end
            SEND: begin
                m_valid = 1'b1;
                if (m_ready && (out_cnt == 3'd5)) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid && m_ready;
    assign dbg_state = state;

    // ----------------------------------------------------------- counters
    // Element counts alone define tile boundaries; s_last never alters them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt    <= 3'd0;
            out_cnt   <= 3'd0;
            frame_err <= 1'b0;
        end else begin
            if (s_fire) begin
                in_cnt <= (in_cnt == 3'd5) ? 3'd0 : in_cnt + 3'd1;
            end
            if (m_fire) begin
                out_cnt <= (out_cnt == 3'd5) ? 3'd0 : out_cnt + 3'd1;
            end
            frame_err <= s_fire && (s_last != (in_cnt == 3'd5));
        end
    end

    // -------------------------------------------------------- tile buffers
    // Arithmetic wraps modulo 2^data_width: no widening, no saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) begin
                d_buf[k] <= '0;
                v_buf[k] <= '0;
            end
        end else begin
            if (s_fire) begin
                for (int k = 0; k < 6; k++) begin
                    if (in_cnt == 3'(k)) begin
                        d_buf[k] <= s_data;
                    end
                end
            end
            if (state == CALC) begin
                for (int c = 0; c < 2; c++) begin
                    v_buf[0 + c] <= d_buf[0 + c] + d_buf[2 + c];
                    v_buf[2 + c] <= d_buf[0 + c] - d_buf[2 + c];
                    v_buf[4 + c] <= d_buf[4 + c] - d_buf[0 + c];
                end
            end
        end
    end

    // --------------------------------------------------------- output mux
    // Outputs are forced to zero outside SEND so nothing stale is visible.
    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        if (state == SEND) begin
            m_last = (out_cnt == 3'd5);
            case (out_cnt)
                3'd0:    m_data = v_buf[0];
                3'd1:    m_data = v_buf[1];
                3'd2:    m_data = v_buf[2];
                3'd3:    m_data = v_buf[3];
                3'd4:    m_data = v_buf[4];
                3'd5:    m_data = v_buf[5];
                default: m_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_wino_btdb_22_21_stream.sv
// -----------------------------------------------------------------------------
// tb_wino_btdb_22_21_stream
//
// Directed bench for the 22_21 Winograd input transform. The main process
// drives tiles and pushes the hand-computed expected v tile into exp_q; a
// separate monitor pops and compares whenever an output beat transfers, and
// also checks that stalled beats stay valid and stable.
// -----------------------------------------------------------------------------
module tb_wino_btdb_22_21_stream;

    localparam int W = 20;

    // ------------------------------------------------------ clock / reset
    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         frame_err;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    wino_btdb_22_21_stream #(.data_width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .frame_err (frame_err),
        .dbg_state (dbg_state)
    );

    // ---------------------------------------------------------- scoreboard
    logic [W:0]   exp_q[$];         // {last, data}
    int           total = 0;
    int           bad   = 0;
    int           rx_cnt = 0;
    int           fe_cnt = 0;
    logic         held_v = 1'b0;
    logic [W:0]   held;
    logic         bp_en = 1'b0;
    logic [3:0]   bp_pat = 4'b1001; // m_ready sequence 1,0,0,1 (bit 0 first)

    logic [W-1:0] stim_d    [12];
    logic         stim_last [12];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------ monitor
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (frame_err) fe_cnt++;
                if (held_v) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data", 32'({m_last, m_data}), 32'(held));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got 0x%0h expected no beat", {m_last, m_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 32'({m_last, m_data}), 32'(e));
                    end
                    rx_cnt++;
                    held_v = 1'b0;
                end else if (m_valid) begin
                    held_v = 1'b1;
                    held   = {m_last, m_data};
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    // --------------------------------------------------- m_ready generator
    initial begin
        int idx = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                m_ready = bp_pat[idx % 4];
                idx++;
            end else begin
                m_ready = 1'b1;
                idx = 0;
            end
        end
    end

    // ----------------------------------------------------- driver tasks
    task automatic set_tile(input int base,
                            input logic [W-1:0] a, b, c, d, e, f,
                            input logic [5:0] last_mask);
        stim_d[base+0] = a; stim_d[base+1] = b; stim_d[base+2] = c;
        stim_d[base+3] = d; stim_d[base+4] = e; stim_d[base+5] = f;
        for (int k = 0; k < 6; k++) stim_last[base+k] = last_mask[k];
    endtask

    task automatic push_tile(input logic [W-1:0] a, b, c, d, e, f);
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b0, c});
        exp_q.push_back({1'b0, d});
        exp_q.push_back({1'b0, e});
        exp_q.push_back({1'b1, f});
    endtask

    // Holds s_valid high from posedge+1 until n beats have been accepted;
    // counts cycles in which s_ready was low.
    task automatic drive(input int n, output int low_cyc);
        int i = 0;
        int guard = 0;
        low_cyc = 0;
        while (i < n && guard < 200) begin
            s_valid = 1'b1;
            s_data  = stim_d[i];
            s_last  = stim_last[i];
            @(negedge clk);
            if (s_ready) i++;
            else low_cyc++;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        if (i < n) begin
            total++;
            bad++;
            $display("FAIL drive_timeout: accepted %0d beats expected %0d", i, n);
        end
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ----------------------------------------------------------- main
    initial begin
        int low;
        int base;
        int guard;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_s_ready", 32'(s_ready), 32'd1);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        check("reset_m_last", 32'(m_last), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic tile: d = 1..6
        set_tile(0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 6'b100000);
        push_tile(20'h00004, 20'h00006, 20'hFFFFE, 20'hFFFFE, 20'h00004, 20'h00004);
        drive(6, low);
        drain("drain_basic");

        // Wrap-around: d0 = 0x7FFFF, d2 = 1
        set_tile(0, 20'h7FFFF, 20'h0, 20'h00001, 20'h0, 20'h0, 20'h0, 6'b100000);
        push_tile(20'h80000, 20'h00000, 20'h7FFFE, 20'h00000, 20'h80001, 20'h00000);
        drive(6, low);
        drain("drain_wrap");
        check("fe_none", 32'(fe_cnt), 32'd0);

        // Back-pressure with m_ready 1,0,0,1,...
        bp_en = 1'b1;
        set_tile(0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 6'b100000);
        push_tile(20'h00004, 20'h00006, 20'hFFFFE, 20'hFFFFE, 20'h00004, 20'h00004);
        drive(6, low);
        drain("drain_bp");
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Two tiles back to back with s_valid held high: 1..6 then 6..1
        set_tile(0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 6'b100000);
        set_tile(6, 20'd6, 20'd5, 20'd4, 20'd3, 20'd2, 20'd1, 6'b100000);
        push_tile(20'h00004, 20'h00006, 20'hFFFFE, 20'hFFFFE, 20'h00004, 20'h00004);
        push_tile(20'h0000A, 20'h00008, 20'h00002, 20'h00002, 20'hFFFFC, 20'hFFFFC);
        drive(12, low);
        check("ready_low_cycles", 32'(low), 32'd7);
        drain("drain_b2b");

        // Framing: s_last on 3rd and 6th element -> exactly one pulse
        fe_cnt = 0;
        set_tile(0, 20'h10, 20'h20, 20'h30, 20'h05, 20'h100, 20'h200, 6'b100100);
        push_tile(20'h00040, 20'h00025, 20'hFFFE0, 20'h0001B, 20'h000F0, 20'h001E0);
        drive(6, low);
        drain("drain_frame");
        check("fe_once", 32'(fe_cnt), 32'd1);

        // Reset after 3 loaded beats, then a fresh tile
        set_tile(0, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h0, 20'h0, 20'h0, 6'b000000);
        drive(3, low);
        do_reset();
        set_tile(0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 6'b100000);
        push_tile(20'h00004, 20'h00006, 20'hFFFFE, 20'hFFFFE, 20'h00004, 20'h00004);
        drive(6, low);
        drain("drain_rst_load");

        // Reset mid-SEND after two beats, then a fresh tile
        set_tile(0, 20'h7FFFF, 20'h0, 20'h00001, 20'h0, 20'h0, 20'h0, 6'b100000);
        push_tile(20'h80000, 20'h00000, 20'h7FFFE, 20'h00000, 20'h80001, 20'h00000);
        base = rx_cnt;
        drive(6, low);
        guard = 0;
        while (rx_cnt < base + 2 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("mid_send_beats", 32'(rx_cnt - base), 32'd2);
        do_reset();
        set_tile(0, 20'd6, 20'd5, 20'd4, 20'd3, 20'd2, 20'd1, 6'b100000);
        push_tile(20'h0000A, 20'h00008, 20'h00002, 20'h00002, 20'hFFFFC, 20'hFFFFC);
        drive(6, low);
        drain("drain_rst_send");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
